// File: rtl/ml_acc_pkg.sv
// Shared constants, address map and FSM encoding for the ml_acc_system compute path.
package ml_acc_pkg;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned ACC_W          = 64;
  localparam int unsigned N_ELEMS        = 25;
  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned IDX_W          = $clog2(N_ELEMS);
  localparam int unsigned DRAIN_CYCLES   = 3;
  localparam int unsigned CTRL_START_REG = 10;

  localparam logic [ADDR_W-1:0] OUTACT_LO_OFF = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] OUTACT_HI_OFF = 32'h0000_0004;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_FETCH    = 3'd1;
  localparam logic [2:0] ST_DRAIN    = 3'd2;
  localparam logic [2:0] ST_WRITE_LO = 3'd3;
  localparam logic [2:0] ST_WRITE_HI = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE     = ST_IDLE,
    S_FETCH    = ST_FETCH,
    S_DRAIN    = ST_DRAIN,
    S_WRITE_LO = ST_WRITE_LO,
    S_WRITE_HI = ST_WRITE_HI,
    S_DONE     = ST_DONE
  } state_e;
endpackage

// File: rtl/mac_pipe.sv
// Valid-tagged multiply/accumulate pipeline: tag follows BRAM latency, product stage, accumulate stage.
module mac_pipe
  import ml_acc_pkg::*;
(
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic                     clr,
  input  logic                     issue,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic        [ACC_W-1:0]  acc
);
  logic                       v_data;
  logic                       v_prod;
  logic signed [2*DATA_W-1:0] prod;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      v_data <= 1'b0;
      v_prod <= 1'b0;
      prod   <= '0;
      acc    <= '0;
    end else if (clr) begin
      v_data <= 1'b0;
      v_prod <= 1'b0;
      prod   <= '0;
      acc    <= '0;
    end else begin
      v_data <= issue;
      v_prod <= v_data;
      if (v_data) prod <= a * b;
      // Only tagged products reach the sum, so idle-time rdata is harmless.
      if (v_prod) acc <= acc + ACC_W'(prod);
    end
  end
endmodule

// File: rtl/conv_dot_engine.sv
// Dot-product engine: start edge detect, BRAM fetch sequencer and two-word result write-back.
module conv_dot_engine
  import ml_acc_pkg::*;
(
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              start_reg,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] in_addr,
  output logic              in_en,
  input  logic [DATA_W-1:0] in_rdata,
  output logic [ADDR_W-1:0] wt_addr,
  output logic              wt_en,
  input  logic [DATA_W-1:0] wt_rdata,
  output logic [ADDR_W-1:0] oa_addr,
  output logic              oa_en,
  output logic [3:0]        oa_we,
  output logic [DATA_W-1:0] oa_wdata
);
  state_e           state;
  logic             start_q;
  logic             armed;
  logic             accept;
  logic             fetch;
  logic [IDX_W-1:0] idx;
  logic [1:0]       drain_cnt;
  logic [ACC_W-1:0] acc;

  // armed masks the first cycle after reset so a level held through reset never fires.
  assign accept = start_reg & ~start_q & armed & ((state == S_IDLE) | (state == S_DONE));
  assign fetch  = (state == S_FETCH);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state     <= S_IDLE;
      start_q   <= 1'b0;
      armed     <= 1'b0;
      idx       <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      start_q <= start_reg;
      armed   <= 1'b1;
      if (accept) begin
        state <= S_FETCH;
        idx   <= '0;
        busy  <= 1'b1;
        done  <= 1'b0;
      end else begin
        unique case (state)
          S_FETCH: begin
            if (idx == IDX_W'(N_ELEMS - 1)) begin
              state     <= S_DRAIN;
              drain_cnt <= '0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
          // Three drain cycles let the final sum settle in acc, so WRITE_LO needs no bypass.
          S_DRAIN: begin
            if (drain_cnt == 2'(DRAIN_CYCLES - 1)) state <= S_WRITE_LO;
            else drain_cnt <= drain_cnt + 2'd1;
          end
          S_WRITE_LO: state <= S_WRITE_HI;
          S_WRITE_HI: begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
          S_IDLE, S_DONE: state <= state;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    in_en    = fetch;
    wt_en    = fetch;
    in_addr  = fetch ? ADDR_W'({idx, 2'b00}) : '0;
    wt_addr  = fetch ? ADDR_W'({idx, 2'b00}) : '0;
    oa_en    = 1'b0;
    oa_we    = '0;
    oa_addr  = '0;
    oa_wdata = '0;
    if (state == S_WRITE_LO) begin
      oa_en    = 1'b1;
      oa_we    = '1;
      oa_addr  = OUTACT_LO_OFF;
      oa_wdata = acc[DATA_W-1:0];
    end else if (state == S_WRITE_HI) begin
      oa_en    = 1'b1;
      oa_we    = '1;
      oa_addr  = OUTACT_HI_OFF;
      oa_wdata = acc[ACC_W-1:DATA_W];
    end
  end

  mac_pipe u_mac (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .clr     (accept),
    .issue   (fetch),
    .a       (in_rdata),
    .b       (wt_rdata),
    .acc     (acc)
  );
endmodule

// File: tb/tb_conv_dot_engine.sv
// Self-checking bench for conv_dot_engine with BRAM models and an arithmetic dot-product reference.
module tb_conv_dot_engine;
  localparam int N = 25;

  logic        tb_ACLK;
  logic        ARESETn;
  logic        start_reg;
  logic        busy, done;
  logic [31:0] in_addr, wt_addr, oa_addr;
  logic        in_en, wt_en, oa_en;
  logic [31:0] in_rdata, wt_rdata, oa_wdata;
  logic [3:0]  oa_we;

  int in_mem [N];
  int wt_mem [N];
  logic [31:0] oa_mem [2];
  int oa_wr_cnt;
  int total, bad;

  conv_dot_engine dut (
    .ACLK      (tb_ACLK),
    .ARESETn   (ARESETn),
    .start_reg (start_reg),
    .busy      (busy),
    .done      (done),
    .in_addr   (in_addr),
    .in_en     (in_en),
    .in_rdata  (in_rdata),
    .wt_addr   (wt_addr),
    .wt_en     (wt_en),
    .wt_rdata  (wt_rdata),
    .oa_addr   (oa_addr),
    .oa_en     (oa_en),
    .oa_we     (oa_we),
    .oa_wdata  (oa_wdata)
  );

  initial tb_ACLK = 1'b0;
  always #5 tb_ACLK = ~tb_ACLK;

  // BRAM models: 1-cycle read latency, random garbage when not enabled.
  always @(posedge tb_ACLK) begin
    if (in_en && in_addr[31:2] < N) in_rdata <= in_mem[in_addr[31:2]];
    else in_rdata <= $urandom;
    if (wt_en && wt_addr[31:2] < N) wt_rdata <= wt_mem[wt_addr[31:2]];
    else wt_rdata <= $urandom;
  end

  initial oa_wr_cnt = 0;
  always @(posedge tb_ACLK) begin
    if (oa_en && oa_we != 4'h0) begin
      oa_wr_cnt <= oa_wr_cnt + 1;
      if (oa_addr == 32'h0) oa_mem[0] <= oa_wdata;
      else if (oa_addr == 32'h4) oa_mem[1] <= oa_wdata;
    end
  end

  function automatic longint golden_sum();
    longint s = 0;
    for (int i = 0; i < N; i++) s += longint'(in_mem[i]) * longint'(wt_mem[i]);
    return s;
  endfunction

  task automatic run_job(input string name, input bit glitch);
    longint gold;
    int     done_cyc, busy_bad, fetch_bad, w0;
    gold      = golden_sum();
    w0        = oa_wr_cnt;
    done_cyc  = -1;
    busy_bad  = 0;
    fetch_bad = 0;
    @(negedge tb_ACLK);
    start_reg = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge tb_ACLK);
      #1;
      if (busy !== (k <= N + 5)) busy_bad++;
      if (in_en !== (k <= N) || wt_en !== (k <= N)) fetch_bad++;
      else if (k <= N && (in_addr !== 32'((k - 1) * 4) || wt_addr !== 32'((k - 1) * 4))) fetch_bad++;
      else if (k > N && (in_addr !== 32'h0 || wt_addr !== 32'h0)) fetch_bad++;
      if (done === 1'b1 && done_cyc < 0) done_cyc = k;
      if (done !== 1'b1 && done_cyc >= 0) busy_bad++;
      if (glitch && k == 5) start_reg = 1'b0;
      if (glitch && k == 8) start_reg = 1'b1;
    end
    total++;
    if (busy_bad != 0) begin bad++; $display("FAIL %s busy/done pattern: bad_cycles=%0d required=0", name, busy_bad); end
    total++;
    if (fetch_bad != 0) begin bad++; $display("FAIL %s fetch enables/addrs: bad_cycles=%0d required=0", name, fetch_bad); end
    total++;
    if (done_cyc != N + 6) begin bad++; $display("FAIL %s done cycle: got=%0d required=%0d", name, done_cyc, N + 6); end
    total++;
    if (oa_wr_cnt - w0 != 2) begin bad++; $display("FAIL %s outact writes: got=%0d required=2", name, oa_wr_cnt - w0); end
    total++;
    if (oa_mem[0] !== gold[31:0]) begin bad++; $display("FAIL %s outact[0]: got=%h required=%h", name, oa_mem[0], gold[31:0]); end
    total++;
    if (oa_mem[1] !== gold[63:32]) begin bad++; $display("FAIL %s outact[1]: got=%h required=%h", name, oa_mem[1], gold[63:32]); end
    @(negedge tb_ACLK);
    start_reg = 1'b0;
    @(negedge tb_ACLK);
  endtask

  task automatic test_reset;
    ARESETn   = 1'b0;
    start_reg = 1'b0;
    #1;
    total++;
    if ({busy, done, in_en, wt_en, oa_en, oa_we, in_addr, wt_addr, oa_addr, oa_wdata} !== '0) begin
      bad++; $display("FAIL reset outputs: got busy=%b done=%b oa_we=%h required all 0", busy, done, oa_we);
    end
    repeat (3) @(negedge tb_ACLK);
    ARESETn = 1'b1;
    repeat (2) @(negedge tb_ACLK);
  endtask

  task automatic test_ramp;
    for (int i = 0; i < N; i++) begin in_mem[i] = i; wt_mem[i] = 1; end
    total++;
    if (golden_sum() != 64'd300) begin bad++; $display("FAIL ramp model: got=%0d required=300", golden_sum()); end
    run_job("ramp", 1'b0);
  endtask

  task automatic test_negative;
    for (int i = 0; i < N; i++) begin in_mem[i] = -3; wt_mem[i] = 2; end
    run_job("negative", 1'b0);
  endtask

  task automatic test_poly;
    for (int i = 0; i < N; i++) begin
      wt_mem[i] = -i * i * i + 3 * i * i + 129;
      in_mem[i] = -2 * i * i * i + 30 * i * i + 231;
    end
    run_job("poly", 1'b0);
  endtask

  task automatic test_random;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) begin in_mem[i] = int'($urandom); wt_mem[i] = int'($urandom); end
      run_job($sformatf("random%0d", r), 1'b0);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < N; i++) begin in_mem[i] = int'($urandom_range(1000)) - 500; wt_mem[i] = i + 7; end
    run_job("midrun_edge", 1'b1);
    for (int i = 0; i < N; i++) in_mem[i] = 0;
    run_job("zero_after_done", 1'b0);
  endtask

  task automatic test_reset_mid_run;
    int w0;
    for (int i = 0; i < N; i++) begin in_mem[i] = int'($urandom); wt_mem[i] = int'($urandom); end
    @(negedge tb_ACLK);
    start_reg = 1'b1;
    repeat (10) @(posedge tb_ACLK);
    @(negedge tb_ACLK);
    w0 = oa_wr_cnt;
    ARESETn = 1'b0;
    #1;
    total++;
    if ({busy, done, in_en, wt_en, oa_en, oa_we, in_addr, wt_addr, oa_addr, oa_wdata} !== '0) begin
      bad++; $display("FAIL midrun reset outputs: got busy=%b in_en=%b in_addr=%h required all 0", busy, in_en, in_addr);
    end
    start_reg = 1'b0;
    repeat (3) @(negedge tb_ACLK);
    ARESETn = 1'b1;
    repeat (40) @(negedge tb_ACLK);
    total++;
    if (oa_wr_cnt != w0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL aborted run idle: writes=%0d busy=%b done=%b required 0/0/0", oa_wr_cnt - w0, busy, done);
    end
    for (int i = 0; i < N; i++) begin in_mem[i] = int'($urandom); wt_mem[i] = int'($urandom); end
    run_job("after_reset", 1'b0);
  endtask

  task automatic test_start_held;
    int activity;
    @(negedge tb_ACLK);
    ARESETn   = 1'b0;
    start_reg = 1'b1;
    repeat (2) @(negedge tb_ACLK);
    ARESETn  = 1'b1;
    activity = 0;
    repeat (15) begin
      @(negedge tb_ACLK);
      if (busy !== 1'b0 || done !== 1'b0 || in_en !== 1'b0) activity++;
    end
    total++;
    if (activity != 0) begin bad++; $display("FAIL held start: active_cycles=%0d required=0", activity); end
    start_reg = 1'b0;
    @(negedge tb_ACLK);
    for (int i = 0; i < N; i++) begin in_mem[i] = N - i; wt_mem[i] = -i; end
    run_job("held_then_toggle", 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_ramp();
    test_negative();
    test_poly();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    test_start_held();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
